// File: rtl/sram_banked.sv
// Banked multi-port SRAM: NumPorts request ports onto NumBanks word-interleaved
// single-port banks, each with round-robin arbitration and a 1-bit tag per word.
module sram_banked #(
   parameter int unsigned         NumPorts    = 2,
   parameter int unsigned         NumBanks    = 2,
   parameter int unsigned         AddrWidth   = 17,
   parameter int unsigned         ReadLatency = 1,
   parameter logic [NumPorts-1:0] PortWriteEn = 2'b01,
   parameter string               InitFile    = ""
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [NumPorts-1:0]    req_i,
   input  logic [NumPorts-1:0]    we_i,
   input  logic [4*NumPorts-1:0]  be_i,
   input  logic [32*NumPorts-1:0] addr_i,
   input  logic [32*NumPorts-1:0] wdata_i,
   input  logic [NumPorts-1:0]    wcap_i,
   output logic [NumPorts-1:0]    gnt_o,
   output logic [NumPorts-1:0]    rvalid_o,
   output logic [32*NumPorts-1:0] rdata_o,
   output logic [NumPorts-1:0]    rcap_o,
   output logic [NumPorts-1:0]    err_o
);
   localparam int unsigned BankBits = $clog2(NumBanks);
   localparam int unsigned BankW    = (NumBanks > 1) ? BankBits : 1;
   localparam int unsigned PortW    = (NumPorts > 1) ? $clog2(NumPorts) : 1;
   localparam int unsigned WordW    = AddrWidth - 2;
   localparam int unsigned RowW     = WordW - BankBits;
   localparam int unsigned Rows     = 2 ** RowW;

   logic [BankW-1:0]    bank  [NumPorts];
   logic [RowW-1:0]     row   [NumPorts];
   logic [3:0]          be    [NumPorts];
   logic [31:0]         wdata [NumPorts];
   logic [NumPorts-1:0] err;
   logic [NumPorts-1:0] gnt;

   logic [NumBanks-1:0] win_valid;
   logic [PortW-1:0]    win_idx    [NumBanks];
   logic [32:0]         bank_rdata [NumBanks];

   logic unused_init;
   assign unused_init = (InitFile != "");

   function automatic logic [PortW-1:0] rr_index(logic [PortW-1:0] base, int unsigned k);
      return PortW'((32'(base) + k) % NumPorts);
   endfunction

   assign gnt_o = gnt;

   for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port
      logic [WordW-1:0] word;
      logic             oor;
      logic             unused_lsb;

      assign word       = addr_i[32*gi+2 +: WordW];
      assign unused_lsb = ^addr_i[32*gi +: 2];
      assign be[gi]     = be_i[4*gi +: 4];
      assign wdata[gi]  = wdata_i[32*gi +: 32];

      if (NumBanks > 1) begin : g_bank_sel
         assign bank[gi] = word[BankW-1:0];
         assign row[gi]  = word[WordW-1:BankW];
      end else begin : g_single_bank
         assign bank[gi] = '0;
         assign row[gi]  = word;
      end

      if (AddrWidth < 32) begin : g_oor
         assign oor = |addr_i[32*gi+AddrWidth +: 32-AddrWidth];
      end else begin : g_no_oor
         assign oor = 1'b0;
      end

      // Error requests are accepted immediately and never reach a bank
      assign err[gi] = oor | (we_i[gi] & ~PortWriteEn[gi]);
      assign gnt[gi] = req_i[gi] & (err[gi] |
                       (win_valid[bank[gi]] & (win_idx[bank[gi]] == PortW'(gi))));

      logic             s1_valid_q;
      logic             s1_err_q;
      logic             s1_rd_q;
      logic [BankW-1:0] s1_bank_q;
      logic             resp_valid;
      logic             resp_err;
      logic [32:0]      resp_word;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_rd_q    <= 1'b0;
            s1_bank_q  <= '0;
         end else begin
            s1_valid_q <= gnt[gi];
            s1_err_q   <= err[gi];
            s1_rd_q    <= ~we_i[gi];
            s1_bank_q  <= bank[gi];
         end
      end

      assign resp_valid = s1_valid_q;
      assign resp_err   = s1_valid_q & s1_err_q;
      assign resp_word  = (s1_valid_q & ~s1_err_q & s1_rd_q) ? bank_rdata[s1_bank_q] : '0;

      if (ReadLatency > 1) begin : g_out_reg
         logic        valid_q;
         logic        err_q;
         logic [32:0] word_q;

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               valid_q <= 1'b0;
               err_q   <= 1'b0;
               word_q  <= '0;
            end else begin
               valid_q <= resp_valid;
               err_q   <= resp_err;
               word_q  <= resp_word;
            end
         end

         assign rvalid_o[gi]         = valid_q;
         assign err_o[gi]            = err_q;
         assign rdata_o[32*gi +: 32] = word_q[31:0];
         assign rcap_o[gi]           = word_q[32];
      end else begin : g_out_direct
         assign rvalid_o[gi]         = resp_valid;
         assign err_o[gi]            = resp_err;
         assign rdata_o[32*gi +: 32] = resp_word[31:0];
         assign rcap_o[gi]           = resp_word[32];
      end
   end

   for (genvar gb = 0; gb < NumBanks; gb++) begin : g_bank
      logic [NumPorts-1:0] bank_req;
      logic                sel_valid;
      logic [PortW-1:0]    sel_idx;
      logic [PortW-1:0]    rr_q;
      logic [PortW-1:0]    rr_d;
      logic [RowW-1:0]     b_row;
      logic                b_we;
      logic [3:0]          b_be;
      logic [31:0]         b_wdata;
      logic                b_wcap;
      logic [32:0]         mem_q [Rows];
      logic [32:0]         rdata_q;

      for (genvar gi = 0; gi < NumPorts; gi++) begin : g_req
         assign bank_req[gi] = req_i[gi] & ~err[gi] & (bank[gi] == BankW'(gb));
      end

      // Round-robin: first requester at or after rr_q, wrapping
      always_comb begin
         sel_valid = 1'b0;
         sel_idx   = '0;
         for (int unsigned k = 0; k < NumPorts; k++) begin
            if (!sel_valid && bank_req[rr_index(rr_q, k)]) begin
               sel_valid = 1'b1;
               sel_idx   = rr_index(rr_q, k);
            end
         end
         rr_d = rr_q;
         if (sel_valid) begin
            rr_d = (sel_idx == PortW'(NumPorts - 1)) ? '0 : sel_idx + PortW'(1);
         end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            rr_q <= '0;
         end else begin
            rr_q <= rr_d;
         end
      end

      assign b_row   = row[sel_idx];
      assign b_we    = we_i[sel_idx];
      assign b_be    = be[sel_idx];
      assign b_wdata = wdata[sel_idx];
      assign b_wcap  = wcap_i[sel_idx];

      // A partial write clears the tag; an empty byte mask leaves the word untouched
      always_ff @(posedge clk_i) begin
         if (sel_valid) begin
            if (b_we) begin
               for (int i = 0; i < 4; i++) begin
                  if (b_be[i]) begin
                     mem_q[b_row][8*i +: 8] <= b_wdata[8*i +: 8];
                  end
               end
               if (|b_be) begin
                  mem_q[b_row][32] <= (&b_be) & b_wcap;
               end
            end else begin
               rdata_q <= mem_q[b_row];
            end
         end
      end

      assign win_valid[gb]  = sel_valid;
      assign win_idx[gb]    = sel_idx;
      assign bank_rdata[gb] = rdata_q;
   end

endmodule

// File: tb/tb_sram_banked.sv
// Scoreboard bench for sram_banked: a ReadLatency=1 and a ReadLatency=2 instance share
// one stimulus stream and are checked against a word-level memory and arbitration model.
module tb_sram_banked;
   localparam int NP = 2;
   localparam int NB = 2;
   localparam int AW = 17;
   localparam logic [NP-1:0] PWE = 2'b01;

   typedef struct {
      int          due;
      logic [31:0] data;
      logic        cap;
      logic        err;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NP-1:0]    req, we, wcap;
   logic [4*NP-1:0]  be;
   logic [32*NP-1:0] addr, wdata;
   logic [NP-1:0]    gnt1, rvalid1, rcap1, err1;
   logic [NP-1:0]    gnt2, rvalid2, rcap2, err2;
   logic [32*NP-1:0] rdata1, rdata2;

   int cyc = 0;
   int n_cmp = 0;
   int n_fail = 0;
   exp_t exq [2*NP][$];
   logic [32:0] mem [int];
   int rr [NB];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sram_banked #(.NumPorts(NP), .NumBanks(NB), .AddrWidth(AW), .ReadLatency(1),
                 .PortWriteEn(PWE)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
      .wdata_i(wdata), .wcap_i(wcap), .gnt_o(gnt1), .rvalid_o(rvalid1), .rdata_o(rdata1),
      .rcap_o(rcap1), .err_o(err1));

   sram_banked #(.NumPorts(NP), .NumBanks(NB), .AddrWidth(AW), .ReadLatency(2),
                 .PortWriteEn(PWE)) dut2 (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
      .wdata_i(wdata), .wcap_i(wcap), .gnt_o(gnt2), .rvalid_o(rvalid2), .rdata_o(rdata2),
      .rcap_o(rcap2), .err_o(err2));

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever a response appears
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < NP; p++) begin
            automatic int          qi = d * NP + p;
            automatic logic        v  = d ? rvalid2[p] : rvalid1[p];
            automatic logic [31:0] rd = d ? rdata2[32*p +: 32] : rdata1[32*p +: 32];
            automatic logic        c  = d ? rcap2[p] : rcap1[p];
            automatic logic        er = d ? err2[p] : err1[p];
            automatic exp_t        e;
            if (v) begin
               if (exq[qi].size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected_rvalid rl%0d p%0d: got rvalid=1, want no response (cycle %0d)",
                           d + 1, p, cyc);
               end else begin
                  e = exq[qi].pop_front();
                  check($sformatf("latency rl%0d p%0d", d + 1, p), 64'(cyc), 64'(e.due));
                  check($sformatf("resp{data,cap,err} rl%0d p%0d", d + 1, p),
                        {30'd0, rd, c, er}, {30'd0, e.data, e.cap, e.err});
               end
            end else begin
               check($sformatf("idle_outputs rl%0d p%0d", d + 1, p), {30'd0, rd, c, er}, 64'd0);
               if (exq[qi].size() != 0 && exq[qi][0].due <= cyc) begin
                  e = exq[qi].pop_front();
                  n_cmp++;
                  n_fail++;
                  $display("FAIL missing_rvalid rl%0d p%0d: got rvalid=0 at cycle %0d, want response due at %0d",
                           d + 1, p, cyc, e.due);
               end
            end
         end
      end
   end

   // One clock of stimulus: predict grants, compare, queue responses, update model
   task automatic step(output logic [NP-1:0] g, input bit rst_after);
      logic [NP-1:0] exp_g;
      logic          e [NP];
      int            w [NP];
      int            b [NP];
      int            p;
      bit            found;
      exp_t          x;
      logic [32:0]   cur;
      #1;
      exp_g = '0;
      for (int i = 0; i < NP; i++) begin
         w[i] = int'(addr[32*i+2 +: AW-2]);
         b[i] = w[i] % NB;
         e[i] = (addr[32*i+AW +: 32-AW] != 0) || (we[i] && !PWE[i]);
         if (req[i] && e[i]) exp_g[i] = 1'b1;
      end
      for (int bk = 0; bk < NB; bk++) begin
         found = 1'b0;
         for (int k = 0; k < NP; k++) begin
            p = (rr[bk] + k) % NP;
            if (!found && req[p] && !e[p] && b[p] == bk) begin
               found    = 1'b1;
               exp_g[p] = 1'b1;
               rr[bk]   = (p + 1) % NP;
            end
         end
      end
      check("gnt rl1", 64'(gnt1), 64'(exp_g));
      check("gnt rl2", 64'(gnt2), 64'(exp_g));
      for (int i = 0; i < NP; i++) begin
         if (exp_g[i]) begin
            x.data = '0;
            x.cap  = 1'b0;
            x.err  = 1'b0;
            if (e[i]) begin
               x.err = 1'b1;
            end else if (!we[i]) begin
               cur    = mem.exists(w[i]) ? mem[w[i]] : 33'd0;
               x.data = cur[31:0];
               x.cap  = cur[32];
            end
            x.due = cyc + 1;
            exq[i].push_back(x);
            x.due = cyc + 2;
            exq[NP+i].push_back(x);
         end
      end
      for (int i = 0; i < NP; i++) begin
         if (exp_g[i] && !e[i] && we[i]) begin
            cur = mem.exists(w[i]) ? mem[w[i]] : 33'd0;
            for (int k = 0; k < 4; k++) begin
               if (be[4*i+k]) cur[8*k +: 8] = wdata[32*i+8*k +: 8];
            end
            if (be[4*i +: 4] != 4'h0) cur[32] = (be[4*i +: 4] == 4'hF) ? wcap[i] : 1'b0;
            mem[w[i]] = cur;
         end
      end
      g = exp_g;
      if (rst_after) begin
         rst_n = 1'b0;
         for (int i = 0; i < 2 * NP; i++) exq[i].delete();
         for (int bk = 0; bk < NB; bk++) rr[bk] = 0;
      end
      @(negedge clk);
   endtask

   task automatic txn(int p, logic w, logic [3:0] bmask, logic [31:0] a, logic [31:0] d, logic c);
      logic [NP-1:0] g;
      int tries;
      req = '0;
      req[p] = 1'b1;
      we[p] = w;
      be[4*p +: 4] = bmask;
      addr[32*p +: 32] = a;
      wdata[32*p +: 32] = d;
      wcap[p] = c;
      g = '0;
      tries = 0;
      while (!g[p] && tries < 8) begin
         step(g, 1'b0);
         tries++;
      end
      if (!g[p]) begin
         n_cmp++;
         n_fail++;
         $display("FAIL txn_timeout p%0d: got no gnt, want gnt within 8 cycles", p);
      end
      req = '0;
   endtask

   task automatic rand_port(int p);
      logic [31:0] a;
      req[p] = ($urandom_range(3) != 0);
      we[p]  = 1'($urandom_range(1));
      be[4*p +: 4] = ($urandom_range(1) == 1) ? 4'hF : 4'($urandom);
      if ($urandom_range(7) == 0) a = 32'h0002_0000 + 32'($urandom_range(4095));
      else a = 32'($urandom_range(15)) * 4 + 32'($urandom_range(3));
      addr[32*p +: 32]  = a;
      wdata[32*p +: 32] = $urandom;
      wcap[p] = 1'($urandom_range(1));
   endtask

   initial begin
      logic [NP-1:0] g;
      rst_n = 1'b0;
      req = '0; we = '0; be = '0; addr = '0; wdata = '0; wcap = '0;
      repeat (2) @(negedge clk);
      check("reset rvalid rl1", 64'(rvalid1), 0);
      check("reset rvalid rl2", 64'(rvalid2), 0);
      check("reset rdata rl1", 64'(rdata1), 0);
      check("reset rdata rl2", 64'(rdata2), 0);
      check("reset rcap/err rl1", 64'({rcap1, err1}), 0);
      check("reset rcap/err rl2", 64'({rcap2, err2}), 0);
      req[0] = 1'b1;
      addr[31:0] = 32'h40;
      #1;
      check("gnt during reset rl1", 64'(gnt1), 64'h1);
      check("gnt during reset rl2", 64'(gnt2), 64'h1);
      req = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int wd = 0; wd <= 16; wd++) txn(0, 1'b1, 4'hF, 32'(wd * 4), $urandom, 1'($urandom_range(1)));
      txn(0, 1'b1, 4'hF, 32'h100, $urandom, 1'b0);

      txn(0, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 1'b1);
      txn(0, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0);
      txn(0, 1'b1, 4'b0011, 32'h100, 32'h0000CAFE, 1'b1);
      txn(0, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0);
      txn(0, 1'b1, 4'h0, 32'h100, 32'h12345678, 1'b1);
      txn(0, 1'b0, 4'hF, 32'h102, 32'h0, 1'b0);

      req = 2'b11; we = '0; addr = {32'h8, 32'h8};
      repeat (4) step(g, 1'b0);
      addr = {32'hC, 32'h8};
      #1;
      check("split banks gnt rl1", 64'(gnt1), 64'h3);
      repeat (4) step(g, 1'b0);
      req = '0;

      txn(1, 1'b1, 4'hF, 32'h40, 32'hBAADF00D, 1'b1);
      txn(0, 1'b0, 4'hF, 32'h40, 32'h0, 1'b0);
      txn(0, 1'b0, 4'hF, 32'h0002_0000, 32'h0, 1'b0);

      txn(0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
      txn(0, 1'b0, 4'hF, 32'h4, 32'h0, 1'b0);
      txn(0, 1'b0, 4'hF, 32'h8, 32'h0, 1'b0);

      g = '1;
      for (int i = 0; i < 600; i++) begin
         for (int p = 0; p < NP; p++) begin
            if (!req[p] || g[p]) rand_port(p);
         end
         step(g, 1'b0);
      end

      req = '0; we = '0;
      req[0] = 1'b1;
      addr[31:0] = 32'h10;
      step(g, 1'b1);
      req = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      req = 2'b11; we = '0; addr = {32'h8, 32'h8};
      #1;
      check("post-reset rr winner rl1", 64'(gnt1), 64'h1);
      check("post-reset rr winner rl2", 64'(gnt2), 64'h1);
      repeat (3) step(g, 1'b0);
      req = '0;

      repeat (4) step(g, 1'b0);
      for (int i = 0; i < 2 * NP; i++) check($sformatf("drain q%0d", i), 64'(exq[i].size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
